// File: rtl/mult_div_seq.sv
// Sequencer for unsigned multu/divu that borrows the shared 32-bit ALU.
// It does one shift-add or restoring shift-subtract step per cycle and owns HI/LO.
module mult_div_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_cout,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIN
    } state_t;

    localparam logic [2:0]       OP_ADD = 3'b010;
    localparam logic [2:0]       OP_SUB = 3'b110;
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic               r_is_div;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_opnd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_div_zero;

    logic [WIDTH-1:0]   w_alu_a;
    logic [WIDTH-1:0]   w_alu_b;
    logic [2:0]         w_alu_op;
    logic               w_no_borrow;

    // The shifted-out HI bit means the partial remainder already exceeds any divisor.
    assign w_no_borrow = r_hi[WIDTH-1] | alu_cout;

    always_comb begin
        w_alu_a  = '0;
        w_alu_b  = '0;
        w_alu_op = 3'b000;
        if (r_state == S_ITER) begin
            if (r_is_div) begin
                w_alu_a  = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
                w_alu_b  = r_opnd;
                w_alu_op = OP_SUB;
            end else begin
                w_alu_a  = r_hi;
                w_alu_b  = r_lo[0] ? r_opnd : '0;
                w_alu_op = OP_ADD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_is_div   <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_opnd     <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_is_div <= op_div;
                        r_cnt    <= '0;
                        if (op_div && (b_in == '0)) begin
                            r_hi       <= a_in;
                            r_lo       <= '1;
                            r_opnd     <= b_in;
                            r_div_zero <= 1'b1;
                            r_done     <= 1'b1;
                            r_state    <= S_FIN;
                        end else begin
                            r_hi       <= '0;
                            r_lo       <= op_div ? a_in : b_in;
                            r_opnd     <= op_div ? b_in : a_in;
                            r_div_zero <= 1'b0;
                            r_busy     <= 1'b1;
                            r_state    <= S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    if (r_is_div) begin
                        r_hi <= w_no_borrow ? alu_res : w_alu_a;
                        r_lo <= {r_lo[WIDTH-2:0], w_no_borrow};
                    end else begin
                        {r_hi, r_lo} <= {alu_cout, alu_res, r_lo[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign alu_a    = w_alu_a;
    assign alu_b    = w_alu_b;
    assign alu_op   = w_alu_op;
    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed bench for mult_div_seq; it supplies a behavioural shared ALU (add / B-invert subtract).
module tb_mult_div_seq;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             start;
    logic             op_div;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cout;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int n_pass  = 0;
    int n_total = 0;

    mult_div_seq #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op_div(op_div),
        .a_in(a_in), .b_in(b_in),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_res(alu_res), .alu_cout(alu_cout),
        .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU: op2 inverts B and supplies carry-in.
    always_comb begin
        logic [WIDTH:0] sum;
        sum = '0;
        if (alu_op == 3'b010)
            sum = {1'b0, alu_a} + {1'b0, alu_b};
        else if (alu_op == 3'b110)
            sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        else
            sum = {1'b0, alu_a & alu_b};
        {alu_cout, alu_res} = sum;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic issue(input logic d, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        start  = 1'b1;
        op_div = d;
        a_in   = a;
        b_in   = b;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // lat is the cycle index (1 = cycle after the start edge) at which done is seen; 0 = timed out.
    task automatic run_to_done(output int lat, output int busy_n, output logic [2:0] first_op);
        lat = 0;
        busy_n = 0;
        first_op = alu_op;
        for (int k = 1; k <= 40; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        op_div = 1'b0;
        a_in = '0;
        b_in = '0;
        #12;
        n_total++;
        if ((hi !== '0) || (lo !== '0) || (busy !== 1'b0) || (done !== 1'b0) ||
            (div_zero !== 1'b0) || (alu_a !== '0) || (alu_b !== '0) || (alu_op !== 3'b000))
            $display("FAIL reset_state: hi=%0h lo=%0h busy=%b done=%b dz=%b op=%b expected all zero",
                     hi, lo, busy, done, div_zero, alu_op);
        else
            n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult_basic();
        int lat, bn;
        logic [2:0] op0;
        issue(1'b0, 32'd7, 32'd6);
        run_to_done(lat, bn, op0);
        chk("mul7x6_latency", 64'(lat), 64'd33);
        chk("mul7x6_busy_cycles", 64'(bn), 64'd32);
        chk("mul7x6_iter_op", 64'(op0), 64'h2);
        chk("mul7x6_hi", 64'(hi), 64'd0);
        chk("mul7x6_lo", 64'(lo), 64'd42);
        @(negedge clk);
    endtask

    task automatic test_mult_max();
        int lat, bn;
        logic [2:0] op0;
        issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_to_done(lat, bn, op0);
        chk("mulmax_latency", 64'(lat), 64'd33);
        chk("mulmax_hi", 64'(hi), 64'hFFFFFFFE);
        chk("mulmax_lo", 64'(lo), 64'h00000001);
        @(negedge clk);
    endtask

    task automatic test_div();
        int lat, bn;
        logic [2:0] op0;
        issue(1'b1, 32'd100, 32'd7);
        run_to_done(lat, bn, op0);
        chk("div100_7_latency", 64'(lat), 64'd33);
        chk("div100_7_iter_op", 64'(op0), 64'h6);
        chk("div100_7_lo", 64'(lo), 64'd14);
        chk("div100_7_hi", 64'(hi), 64'd2);
        chk("div100_7_dz", 64'(div_zero), 64'd0);
        @(negedge clk);
        issue(1'b1, 32'hFFFFFFFF, 32'd2);
        run_to_done(lat, bn, op0);
        chk("divmax_2_lo", 64'(lo), 64'h7FFFFFFF);
        chk("divmax_2_hi", 64'(hi), 64'd1);
        @(negedge clk);
        issue(1'b1, 32'd5, 32'h80000001);
        run_to_done(lat, bn, op0);
        chk("div5_big_lo", 64'(lo), 64'd0);
        chk("div5_big_hi", 64'(hi), 64'd5);
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int lat, bn;
        logic [2:0] op0;
        issue(1'b1, 32'd9, 32'd0);
        run_to_done(lat, bn, op0);
        chk("divzero_latency", 64'(lat), 64'd1);
        chk("divzero_busy_cycles", 64'(bn), 64'd0);
        chk("divzero_flag", 64'(div_zero), 64'd1);
        chk("divzero_hi", 64'(hi), 64'd9);
        chk("divzero_lo", 64'(lo), 64'hFFFFFFFF);
        @(negedge clk);
        chk("divzero_flag_held", 64'(div_zero), 64'd1);
        issue(1'b0, 32'd3, 32'd3);
        chk("divzero_cleared_on_start", 64'(div_zero), 64'd0);
        run_to_done(lat, bn, op0);
        chk("mul3x3_lo", 64'(lo), 64'd9);
        chk("mul3x3_hi", 64'(hi), 64'd0);
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int lat = 0;
        issue(1'b0, 32'd1000, 32'd1000);
        for (int k = 1; k <= 40; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (k == 10) begin
                start = 1'b1; op_div = 1'b1; a_in = 32'd50; b_in = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("ignore_latency", 64'(lat), 64'd33);
        chk("ignore_mid_lo", 64'(lo), 64'd1000000);
        issue(1'b1, 32'd50, 32'd3);
        chk("ignore_fin_busy", 64'(busy), 64'd0);
        chk("ignore_fin_idle_op", 64'(alu_op), 64'h0);
        @(negedge clk);
        chk("ignore_fin_busy_later", 64'(busy), 64'd0);
        chk("ignore_fin_lo", 64'(lo), 64'd1000000);
        chk("ignore_fin_hi", 64'(hi), 64'd0);
    endtask

    task automatic test_reset_mid();
        int lat, bn, dn;
        logic [2:0] op0;
        issue(1'b0, 32'd7, 32'd6);
        repeat (16) @(negedge clk);
        chk("midrst_busy_before", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_async_hi", 64'(hi), 64'd0);
        chk("midrst_async_lo", 64'(lo), 64'd0);
        chk("midrst_async_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) dn++;
            @(negedge clk);
        end
        chk("midrst_no_done", 64'(dn), 64'd0);
        issue(1'b0, 32'd5, 32'd5);
        run_to_done(lat, bn, op0);
        chk("after_rst_latency", 64'(lat), 64'd33);
        chk("after_rst_lo", 64'(lo), 64'd25);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mult_basic();
        test_mult_max();
        test_div();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
